// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 active-low select decoder among
// 8 requesters. Drives the decoder (sel, enable) and an equivalent registered
// active-low one-hot grant vector. A grant lasts at most HOLD_MAX cycles and is
// followed by one dead cycle (RELEASE) before the arbiter returns to IDLE.
module rr_decoder_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [2:0] enable,
    output logic [7:0] grant_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       sel_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [2:0]       winner;
    logic             found;
    logic             grant_end;

    // Search from ptr upward (mod 8) for the first active request.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!found && req[ptr + 3'(k)]) begin
                winner = ptr + 3'(k);
                found  = 1'b1;
            end
        end
    end

    // A grant ends when its owner lets go or the hold limit is reached; both at
    // once still count as a single end, so ptr advances only once.
    assign grant_end = !req[sel] || (hold_cnt == CNT_W'(HOLD_MAX));

    // Next-state logic; everything defaults to holding its value.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n   = winner;
                    hold_n  = CNT_W'(1);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_n = RELEASE;
                    ptr_n   = sel + 3'd1;
                end else begin
                    hold_n = hold_cnt + CNT_W'(1);
                end
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state so
    // grant_n/enable appear one edge after the winning request is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            sel      <= 3'd0;
            hold_cnt <= '0;
            enable   <= 3'b000;
            grant_n  <= 8'hFF;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            hold_cnt <= hold_n;
            enable   <= (state_n == GRANT) ? 3'b100 : 3'b000;
            grant_n  <= (state_n == GRANT) ? ~(8'b1 << sel_n) : 8'hFF;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: directed vector table, fairness
// and coincident-end sequences, then random requests against a reference model.
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel4, en4, sel3, en3;
    logic [7:0] gn4, gn3;
    logic       busy4, busy3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .sel(sel4), .enable(en4), .grant_n(gn4), .busy(busy4)
    );

    rr_decoder_arbiter #(.HOLD_MAX(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .req(req),
        .sel(sel3), .enable(en3), .grant_n(gn3), .busy(busy3)
    );

    // Reference model of the HOLD_MAX=4 instance: who owns the decoder, how
    // many grant cycles it has served, whether we are in the dead cycle.
    int m_owner  = -1;
    int m_served = 0;
    bit m_dead   = 0;
    int m_ptr    = 0;
    int m_sel    = 0;

    task automatic model_edge(input logic [7:0] r, input logic rs);
        if (rs) begin
            m_owner = -1; m_dead = 0; m_ptr = 0; m_sel = 0; m_served = 0;
        end else if (m_dead) begin
            m_dead = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner] || m_served == 4) begin
                m_dead  = 1;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_served++;
            end
        end else if (r != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
                    m_owner  = (m_ptr + k) % 8;
                    m_sel    = m_owner;
                    m_served = 1;
                end
            end
        end
    endtask

    function automatic logic [14:0] model_out();
        logic [7:0] gn;
        logic [2:0] en;
        gn = 8'hFF;
        en = 3'b000;
        if (m_owner >= 0) begin
            gn = ~(8'b1 << m_owner);
            en = 3'b100;
        end
        return {3'(m_sel), en, gn, (m_owner >= 0) || m_dead};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got sel=%0d en=%b gn=%h busy=%b, want sel=%0d en=%b gn=%h busy=%b",
                     name, act[14:12], act[11:9], act[8:1], act[0],
                     exp[14:12], exp[11:9], exp[8:1], exp[0]);
        end else begin
            n_pass++;
        end
    endtask

    // Apply inputs, let one edge pass, then sample 1 time unit later.
    task automatic step(input logic [7:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [2:0] sel;
        logic [2:0] en;
        logic [7:0] gn;
        logic       busy;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Reset, single request, wrap from ptr=7, reset mid-grant.
        tbl[0]  = '{1'b1, 8'hFF, 3'd0, 3'b000, 8'hFF, 1'b0};
        tbl[1]  = '{1'b1, 8'hFF, 3'd0, 3'b000, 8'hFF, 1'b0};
        tbl[2]  = '{1'b0, 8'h08, 3'd3, 3'b100, 8'hF7, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 3'd3, 3'b000, 8'hFF, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 3'd3, 3'b000, 8'hFF, 1'b0};
        tbl[5]  = '{1'b0, 8'h40, 3'd6, 3'b100, 8'hBF, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 3'd6, 3'b000, 8'hFF, 1'b1};
        tbl[7]  = '{1'b0, 8'h41, 3'd6, 3'b000, 8'hFF, 1'b0};
        tbl[8]  = '{1'b0, 8'h41, 3'd0, 3'b100, 8'hFE, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 3'd0, 3'b000, 8'hFF, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 3'd0, 3'b000, 8'hFF, 1'b0};
        tbl[11] = '{1'b0, 8'h20, 3'd5, 3'b100, 8'hDF, 1'b1};
        tbl[12] = '{1'b1, 8'h20, 3'd0, 3'b000, 8'hFF, 1'b0};
        tbl[13] = '{1'b0, 8'h21, 3'd0, 3'b100, 8'hFE, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 3'd0, 3'b000, 8'hFF, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 3'd0, 3'b000, 8'hFF, 1'b0};

        rst = 1'b1;
        req = 8'h00;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req, tbl[i].rst);
            chk($sformatf("vec%0d", i), {sel4, en4, gn4, busy4},
                {tbl[i].sel, tbl[i].en, tbl[i].gn, tbl[i].busy});
        end

        // Fairness with all requests held: each grant is 4 grant cycles, one
        // dead cycle and one idle cycle, owners rotating 0..7 then 0 again.
        step(8'h00, 1'b1);
        for (int t = 0; t < 50; t++) begin
            int owner;
            logic [14:0] exp;
            step(8'hFF, 1'b0);
            owner = (t / 6) % 8;
            if (t % 6 < 4)
                exp = {3'(owner), 3'b100, ~(8'b1 << owner), 1'b1};
            else
                exp = {3'(owner), 3'b000, 8'hFF, (t % 6) == 4};
            chk($sformatf("fair_t%0d", t), {sel4, en4, gn4, busy4}, exp);
        end

        // Coincident end on the HOLD_MAX=3 instance: req[0] drops on the same
        // edge that sees hold_cnt==3; ptr must land on 1, not 2.
        step(8'h00, 1'b1);
        step(8'h01, 1'b0);
        chk("coin_g1", {sel3, en3, gn3, busy3}, {3'd0, 3'b100, 8'hFE, 1'b1});
        step(8'h01, 1'b0);
        step(8'h01, 1'b0);
        chk("coin_g3", {sel3, en3, gn3, busy3}, {3'd0, 3'b100, 8'hFE, 1'b1});
        step(8'h00, 1'b0);
        chk("coin_rel", {sel3, en3, gn3, busy3}, {3'd0, 3'b000, 8'hFF, 1'b1});
        step(8'h00, 1'b0);
        chk("coin_idle", {sel3, en3, gn3, busy3}, {3'd0, 3'b000, 8'hFF, 1'b0});
        step(8'h03, 1'b0);
        chk("coin_next", {sel3, en3, gn3, busy3}, {3'd1, 3'b100, 8'hFD, 1'b1});

        // Hold limit on HOLD_MAX=3 instance: exactly 3 grant cycles.
        step(8'h00, 1'b1);
        for (int t = 0; t < 5; t++) begin
            step(8'h04, 1'b0);
            chk($sformatf("hold3_t%0d", t), {sel3, en3, gn3, busy3},
                (t < 3) ? {3'd2, 3'b100, 8'hFB, 1'b1} : {3'd2, 3'b000, 8'hFF, t == 3});
        end

        // Random traffic against the model, with occasional resets.
        step(8'h00, 1'b1);
        for (int t = 0; t < 600; t++) begin
            logic [7:0] r;
            logic       rs;
            r  = 8'($urandom) & 8'($urandom);
            rs = ($urandom_range(0, 63) == 0);
            step(r, rs);
            chk($sformatf("rand_t%0d", t), {sel4, en4, gn4, busy4}, model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
